// File: rtl/nco_ctrl_pkg.sv
// Shared state encoding and default widths for the NCO frequency-sweep controller.
// Pure declarations: no latency, no flow control.
package nco_ctrl_pkg;

    localparam int APR_DEF = 32;
    localparam int NSW_DEF = 16;
    localparam int DWW_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DWELL  = 2'd2,
        ST_DONE   = 2'd3
    } sweep_state_t;

endpackage

// File: rtl/nco_dwell_timer.sv
// Loadable down-counter; term is high while the count sits at zero.
// Load takes effect on the next edge; counting stalls at zero and only advances while en is high.
module nco_dwell_timer
    import nco_ctrl_pkg::*;
#(
    parameter int DWW = DWW_DEF
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           load,
    input  logic           en,
    input  logic [DWW-1:0] load_val,
    output logic           term
);

    logic [DWW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - DWW'(1);
        end
    end

    assign term = (cnt == '0);

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Steps an NCO phase increment through a linear sweep, holding each frequency for a programmable dwell.
// Outputs change one cycle after the deciding edge; the only backpressure is nco_valid gating SETTLE.
module nco_sweep_ctrl
    import nco_ctrl_pkg::*;
#(
    parameter int APR = APR_DEF,
    parameter int NSW = NSW_DEF,
    parameter int DWW = DWW_DEF
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           start,
    input  logic           abort,
    input  logic [APR-1:0] cfg_start_inc,
    input  logic [APR-1:0] cfg_step,
    input  logic [NSW-1:0] cfg_nsteps,
    input  logic [DWW-1:0] cfg_dwell,
    input  logic [APR-1:0] cfg_fmod,
    input  logic           cfg_repeat,
    input  logic           nco_valid,
    output logic [APR-1:0] phi_inc_o,
    output logic [APR-1:0] freq_mod_o,
    output logic           nco_clken,
    output logic           busy,
    output logic           done,
    output logic           hop,
    output logic [NSW-1:0] step_idx
);

    sweep_state_t   state, state_nxt;
    logic [APR-1:0] start_inc_q, step_q;
    logic [NSW-1:0] nsteps_q;
    logic [DWW-1:0] dwell_q;
    logic           repeat_q;

    logic tmr_load, tmr_term;
    logic go, adv, wrap;

    nco_dwell_timer #(.DWW(DWW)) u_dwell (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (tmr_load),
        .en       (state == ST_DWELL),
        .load_val (dwell_q),
        .term     (tmr_term)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // abort is tested before nco_valid and the dwell terminal so it always wins
    always_comb begin
        state_nxt = state;
        tmr_load  = 1'b0;
        go        = 1'b0;
        adv       = 1'b0;
        wrap      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !abort) begin
                    go        = 1'b1;
                    state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (nco_valid) begin
                    tmr_load  = 1'b1;
                    state_nxt = ST_DWELL;
                end
            end
            ST_DWELL: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (tmr_term) begin
                    if (step_idx < nsteps_q) begin
                        adv      = 1'b1;
                        tmr_load = 1'b1;
                    end else if (repeat_q) begin
                        wrap     = 1'b1;
                        tmr_load = 1'b1;
                    end else begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            start_inc_q <= '0;
            step_q      <= '0;
            nsteps_q    <= '0;
            dwell_q     <= '0;
            repeat_q    <= 1'b0;
            phi_inc_o   <= '0;
            freq_mod_o  <= '0;
            step_idx    <= '0;
            hop         <= 1'b0;
        end else begin
            hop <= adv | wrap;
            if (go) begin
                start_inc_q <= cfg_start_inc;
                step_q      <= cfg_step;
                nsteps_q    <= cfg_nsteps;
                dwell_q     <= cfg_dwell;
                repeat_q    <= cfg_repeat;
                phi_inc_o   <= cfg_start_inc;
                freq_mod_o  <= cfg_fmod;
                step_idx    <= '0;
            end else if (adv) begin
                phi_inc_o <= phi_inc_o + step_q;
                step_idx  <= step_idx + NSW'(1);
            end else if (wrap) begin
                phi_inc_o <= start_inc_q;
                step_idx  <= '0;
            end
        end
    end

    assign busy      = (state == ST_SETTLE) || (state == ST_DWELL);
    assign nco_clken = busy;
    assign done      = (state == ST_DONE);

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Directed bench: expected per-cycle output traces are generated from the sweep rules and compared every cycle.
module tb_nco_sweep_ctrl;

    localparam int APR = 32;
    localparam int NSW = 16;
    localparam int DWW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset_n, start, abort, cfg_repeat, nco_valid;
    logic [APR-1:0] cfg_start_inc, cfg_step, cfg_fmod;
    logic [NSW-1:0] cfg_nsteps;
    logic [DWW-1:0] cfg_dwell;
    logic [APR-1:0] phi_inc_o, freq_mod_o;
    logic           nco_clken, busy, done, hop;
    logic [NSW-1:0] step_idx;

    nco_sweep_ctrl #(.APR(APR), .NSW(NSW), .DWW(DWW)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .abort         (abort),
        .cfg_start_inc (cfg_start_inc),
        .cfg_step      (cfg_step),
        .cfg_nsteps    (cfg_nsteps),
        .cfg_dwell     (cfg_dwell),
        .cfg_fmod      (cfg_fmod),
        .cfg_repeat    (cfg_repeat),
        .nco_valid     (nco_valid),
        .phi_inc_o     (phi_inc_o),
        .freq_mod_o    (freq_mod_o),
        .nco_clken     (nco_clken),
        .busy          (busy),
        .done          (done),
        .hop           (hop),
        .step_idx      (step_idx)
    );

    typedef struct packed {
        logic [APR-1:0] phi;
        logic [APR-1:0] fmod;
        logic [NSW-1:0] idx;
        logic           clken;
        logic           busy;
        logic           done;
        logic           hop;
    } exp_t;

    exp_t  trace[$];
    exp_t  plan[$];
    exp_t  last;
    int    tests = 0;
    int    fails = 0;
    int    dut_hops = 0;
    int    dut_dones = 0;
    string tag = "reset";

    exp_t ce;
    always @(negedge clk) begin
        if (hop)  dut_hops++;
        if (done) dut_dones++;
        if (trace.size() > 0) begin
            ce = trace.pop_front();
            tests++;
            if ({phi_inc_o, freq_mod_o, step_idx, nco_clken, busy, done, hop} !== ce) begin
                fails++;
                $display("FAIL %s: got phi=%h fmod=%h idx=%0d clken=%b busy=%b done=%b hop=%b, want phi=%h fmod=%h idx=%0d clken=%b busy=%b done=%b hop=%b",
                         tag, phi_inc_o, freq_mod_o, step_idx, nco_clken, busy, done, hop,
                         ce.phi, ce.fmod, ce.idx, ce.clken, ce.busy, ce.done, ce.hop);
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic cyc(input exp_t e);
        trace.push_back(e);
        last = e;
        tick();
    endtask

    function automatic exp_t idle_of(input exp_t e);
        exp_t r;
        r       = e;
        r.clken = 1'b0;
        r.busy  = 1'b0;
        r.done  = 1'b0;
        r.hop   = 1'b0;
        return r;
    endfunction

    // Expected outputs after each edge from the start edge on: settle cycles, then each
    // frequency start+i*step for dwell+1 cycles, then a done cycle (or wrap when repeating).
    task automatic build_plan(input logic [APR-1:0] si, input logic [APR-1:0] st, input int ns,
                              input int dw, input logic [APR-1:0] fm, input bit rp,
                              input int nlow, input int limit);
        exp_t e;
        int   rep;
        bit   fin;
        plan.delete();
        e = '0;
        e.phi = si; e.fmod = fm; e.idx = '0; e.clken = 1'b1; e.busy = 1'b1;
        for (int j = 0; j <= nlow; j++) plan.push_back(e);
        rep = 0;
        fin = 1'b0;
        while (!fin && plan.size() < limit) begin
            for (int i = 0; i <= ns; i++) begin
                for (int c = 0; c <= dw; c++) begin
                    if (plan.size() < limit) begin
                        e.phi = 32'(si + st * 32'(i));
                        e.idx = NSW'(i);
                        e.hop = (c == 0) && (i > 0 || rep > 0);
                        plan.push_back(e);
                    end
                end
            end
            if (!rp) begin
                if (plan.size() < limit) begin
                    e.clken = 1'b0; e.busy = 1'b0; e.done = 1'b1; e.hop = 1'b0;
                    plan.push_back(e);
                end
                fin = 1'b1;
            end
            rep++;
        end
    endtask

    // endk: 0 = natural end, 1 = abort after the last planned cycle, 2 = reset after it
    task automatic run_sweep(input string name, input logic [APR-1:0] si, input logic [APR-1:0] st,
                             input int ns, input int dw, input logic [APR-1:0] fm, input bit rp,
                             input int nlow, input int limit, input int endk);
        tag = name;
        build_plan(si, st, ns, dw, fm, rp, nlow, limit);
        for (int j = 0; j < plan.size(); j++) begin
            start     = (j == 0) || (j == 2);
            abort     = 1'b0;
            nco_valid = (j > nlow);
            if (j == 0) begin
                cfg_start_inc = si;
                cfg_step      = st;
                cfg_nsteps    = NSW'(ns);
                cfg_dwell     = DWW'(dw);
                cfg_fmod      = fm;
                cfg_repeat    = rp;
            end else begin
                cfg_start_inc = $urandom;
                cfg_step      = $urandom;
                cfg_nsteps    = NSW'($urandom);
                cfg_dwell     = DWW'($urandom);
                cfg_fmod      = $urandom;
                cfg_repeat    = 1'($urandom);
            end
            cyc(plan[j]);
        end
        start = 1'b0;
        if (endk == 1) begin
            abort = 1'b1;
            cyc(idle_of(last));
            abort = 1'b0;
        end else if (endk == 2) begin
            reset_n = 1'b0;
            cyc('0);
            reset_n = 1'b1;
        end
        cyc(idle_of(last));
        @(negedge clk);
        #1;
    endtask

    int h0, d0;

    initial begin
        reset_n = 1'b0; start = 1'b1; abort = 1'b1; nco_valid = 1'b1;
        cfg_start_inc = 32'h12345678; cfg_step = 32'h1; cfg_nsteps = 16'd2;
        cfg_dwell = 16'd1; cfg_fmod = 32'hFFFF0000; cfg_repeat = 1'b1;
        cyc('0);
        cyc('0);
        reset_n = 1'b1; start = 1'b0; abort = 1'b0;
        cyc('0);

        h0 = dut_hops; d0 = dut_dones;
        run_sweep("sweep4", 32'h01000000, 32'h00100000, 3, 4, 32'h0000ABCD, 1'b0, 0, 1000, 0);
        check("sweep4_len", 64'(plan.size()), 64'd22);
        check("sweep4_f1", 64'(plan[6].phi), 64'h01100000);
        check("sweep4_f3", 64'(plan[16].phi), 64'h01300000);
        check("sweep4_hops", 64'(dut_hops - h0), 64'd3);
        check("sweep4_dones", 64'(dut_dones - d0), 64'd1);

        h0 = dut_hops; d0 = dut_dones;
        run_sweep("settle", 32'h00400000, 32'h00010000, 1, 2, 32'h00000011, 1'b0, 11, 1000, 0);
        check("settle_last_clken", 64'(plan[11].clken), 64'd1);
        check("settle_len", 64'(plan.size()), 64'd19);
        check("settle_dones", 64'(dut_dones - d0), 64'd1);

        run_sweep("negstep", 32'h00080000, 32'hFFF00000, 2, 1, 32'h00000022, 1'b0, 0, 1000, 0);
        check("negstep_f1", 64'(plan[3].phi), 64'hFFF80000);
        check("negstep_f2", 64'(plan[5].phi), 64'hFFE80000);

        h0 = dut_hops; d0 = dut_dones;
        run_sweep("repeat", 32'h00200000, 32'h00300000, 1, 0, 32'h00000033, 1'b1, 0, 12, 1);
        check("repeat_f1", 64'(plan[2].phi), 64'h00500000);
        check("repeat_wrap", 64'(plan[3].phi), 64'h00200000);
        check("repeat_hops", 64'(dut_hops - h0), 64'd10);
        check("repeat_dones", 64'(dut_dones - d0), 64'd0);

        h0 = dut_hops; d0 = dut_dones;
        run_sweep("abort_term", 32'h02000000, 32'h00010000, 3, 3, 32'h00000044, 1'b0, 0, 9, 1);
        check("abort_hops", 64'(dut_hops - h0), 64'd1);
        check("abort_dones", 64'(dut_dones - d0), 64'd0);
        check("abort_hold_phi", 64'(phi_inc_o), 64'h02010000);

        tag = "start_abort_idle";
        start = 1'b1; abort = 1'b1;
        cfg_start_inc = 32'h0ABC0000; cfg_fmod = 32'h55; cfg_nsteps = 16'd1; cfg_dwell = 16'd0;
        cyc(idle_of(last));
        cyc(idle_of(last));
        start = 1'b0; abort = 1'b0;
        cyc(idle_of(last));

        run_sweep("reset_mid", 32'h03000000, 32'h00001000, 2, 5, 32'h00000066, 1'b0, 0, 4, 2);
        check("reset_fmod", 64'(freq_mod_o), 64'h0);

        h0 = dut_hops; d0 = dut_dones;
        run_sweep("restart_n0", 32'h00100000, 32'h00100000, 0, 2, 32'h00000077, 1'b0, 0, 1000, 0);
        check("n0_len", 64'(plan.size()), 64'd5);
        check("n0_hops", 64'(dut_hops - h0), 64'd0);
        check("n0_dones", 64'(dut_dones - d0), 64'd1);

        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/nco_sweep_ctrl.md
NCO_SWEEP_CTRL -- requirements
Module: nco_sweep_ctrl

Interface
REQ-001 SHALL have parameter APR, default 32: phase-increment / freq-mod word width, matching NCO apr/aprf.
REQ-002 SHALL have parameter NSW, default 16: step-count and step-index width.
REQ-003 SHALL have parameter DWW, default 16: dwell-count width.
REQ-004 SHALL have port clk  in  1  single clock, all logic on its rising edge.
REQ-005 SHALL have port reset_n  in  1  synchronous, active-low reset.
REQ-006 SHALL have port start  in  1  one-cycle request to begin a sweep.
REQ-007 SHALL have port abort  in  1  terminate sweep immediately.
REQ-008 SHALL have port cfg_start_inc  in  APR  first phase increment.
REQ-009 SHALL have port cfg_step  in  APR  two's-complement increment added per hop.
REQ-010 SHALL have port cfg_nsteps  in  NSW  number of hops after the first frequency.
REQ-011 SHALL have port cfg_dwell  in  DWW  dwell length minus one, in clk cycles.
REQ-012 SHALL have port cfg_fmod  in  APR  frequency-modulation word held for the whole sweep.
REQ-013 SHALL have port cfg_repeat  in  1  1 = restart at cfg_start_inc after the last hop.
REQ-014 SHALL have port nco_valid  in  1  NCO out_valid.
REQ-015 SHALL have port phi_inc_o  out  APR  to NCO phi_inc_i.
REQ-016 SHALL have port freq_mod_o  out  APR  to NCO freq_mod_i.
REQ-017 SHALL have port nco_clken  out  1  to NCO clken.
REQ-018 SHALL have port busy  out  1  sweep in progress.
REQ-019 SHALL have port done  out  1  one-cycle pulse on normal completion.
REQ-020 SHALL have port hop  out  1  one-cycle pulse when phi_inc_o changes mid-sweep.
REQ-021 SHALL have port step_idx  out  NSW  index of the frequency currently applied.

Function
REQ-022 SHALL implement states IDLE, SETTLE, DWELL and DONE, all registered.
REQ-023 IDLE: on start=1 and abort=0, SHALL latch all cfg_* inputs, set phi_inc_o=cfg_start_inc, freq_mod_o=cfg_fmod and step_idx=0, and enter SETTLE; busy and nco_clken SHALL go 1 on the next cycle.
REQ-024 SETTLE: SHALL wait for nco_valid=1 to cover NCO pipeline fill, then load the dwell counter with cfg_dwell and enter DWELL.
REQ-025 DWELL: the counter SHALL decrement each cycle, so each frequency is held for cfg_dwell+1 cycles; cfg_dwell=0 gives 1 cycle.
REQ-026 At dwell terminal, if step_idx<cfg_nsteps, SHALL set phi_inc_o=phi_inc_o+cfg_step modulo 2^APR (wrap, no saturation), increment step_idx, pulse hop and reload dwell.
REQ-027 At dwell terminal, if step_idx==cfg_nsteps and cfg_repeat=1, SHALL reload cfg_start_inc, set step_idx=0, pulse hop, reload dwell and stay in DWELL with no re-settle.
REQ-028 At dwell terminal, if step_idx==cfg_nsteps and cfg_repeat=0, SHALL enter DONE.
REQ-029 DONE: SHALL pulse done=1 for one cycle with busy=0 and nco_clken=0, then return to IDLE; phi_inc_o and freq_mod_o SHALL hold their last values.
REQ-030 nco_clken SHALL be 1 exactly in SETTLE and DWELL; busy SHALL be 1 exactly in SETTLE and DWELL.
REQ-031 abort=1 in any non-IDLE state SHALL force IDLE on the next cycle, with no done pulse, nco_clken=0 and outputs held.
REQ-032 abort SHALL take priority over start and over dwell terminal.
REQ-033 start SHALL be ignored while busy=1 or in DONE; cfg_* changes mid-sweep SHALL have no effect.
REQ-034 cfg_nsteps=0 SHALL give a single frequency, then done (or indefinite hold if cfg_repeat=1, with a hop pulse every dwell).

Reset
REQ-035 reset_n=0 at a clock edge SHALL set state=IDLE and all outputs, counters and latched config to 0, overriding start and abort.

Structure
REQ-036 Package nco_ctrl_pkg SHALL hold the state encoding and the default APR/NSW/DWW constants.
REQ-037 The dwell counter SHALL be sub-module nco_dwell_timer: a loadable DWW-bit down-counter with terminal flag.

Verification
REQ-038 Bench SHALL cover: start_inc=0x01000000, step=0x00100000, nsteps=3, dwell=4, repeat=0 -> phi_inc_o 0x01000000/0x01100000/0x01200000/0x01300000, each 5 cycles, 3 hop pulses, one done pulse.
REQ-039 Bench SHALL cover: nco_valid held low 11 cycles after start -> stays in SETTLE with nco_clken=1 and step_idx=0 until valid.
REQ-040 Bench SHALL cover: step=0xFFF00000 (negative), start_inc=0x00080000 -> second increment 0xFFF80000 (wrap).
REQ-041 Bench SHALL cover: repeat=1, nsteps=1, dwell=0 -> phi_inc_o alternates every cycle with hop each cycle and no done.
REQ-042 Bench SHALL cover: abort asserted on the same cycle as dwell terminal -> IDLE next cycle, no hop, no done; start+abort in IDLE -> stays IDLE.
REQ-043 Bench SHALL cover: reset_n low mid-DWELL -> all outputs 0 on the following edge, then a restart after reset_n high runs normally.
